// File: rtl/if_id_buf_pkg.sv
// Shared types and constants for the IF/ID fetch buffer.
package if_id_buf_pkg;

    // Width of a fetch address and of an instruction word.
    localparam int WORD_W = 32;

    // Bubble instruction (addi x0, x0, 0) shown to ID when nothing is buffered.
    localparam logic [WORD_W-1:0] INS_NOP = 32'h00000013;

    // Address shown to ID alongside the bubble.
    localparam logic [WORD_W-1:0] RST_ADDR_DEF = 32'h00000000;

    // One buffered fetch: the PC and the instruction fetched from it.
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] ins;
    } fetch_entry_t;

endpackage : if_id_buf_pkg

// File: rtl/if_id_buf.sv
// IF/ID pipeline buffer: a small circular FIFO of {addr, ins} entries.
// The buffer sits between the fetch unit and decode.
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid and ready are both high and no flush is requested. Ready towards
// IF depends only on registered occupancy, so there is no combinational path
// from decode's ready back to fetch. The producer holds its entry stable while
// valid && !ready. Flush discards everything, including any same-cycle transfer.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] NOP_INS  = INS_NOP,
    parameter logic [WORD_W-1:0] RST_ADDR = RST_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WORD_W-1:0]          if2ifid_addr_i,
    input  logic [WORD_W-1:0]          if2ifid_ins_i,
    input  logic                       if2ifid_valid_i,
    output logic                       ifid2if_ready_o,
    input  logic                       ex2ifid_flush_i,
    input  logic                       id2ifid_ready_i,
    output logic                       ifid2id_valid_o,
    output logic [WORD_W-1:0]          ifid2id_addr_o,
    output logic [WORD_W-1:0]          ifid2id_ins_o,
    output logic [$clog2(DEPTH):0]     ifid_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  head;
    logic          push;
    logic          pop;
    logic          not_full;
    logic          not_empty;

    // Occupancy flags are pure functions of the registered count.
    assign not_full  = (count < DEPTH_C);
    assign not_empty = (count != '0);

    // Transfer qualifiers; flush suppresses both sides of the exchange.
    assign push = if2ifid_valid_i && not_full  && !ex2ifid_flush_i;
    assign pop  = id2ifid_ready_i && not_empty && !ex2ifid_flush_i;

    // Pointer and occupancy bookkeeping; flush returns to the reset layout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ex2ifid_flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; left unreset because it is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: if2ifid_addr_i, ins: if2ifid_ins_i};
        end
    end

    // Head of the queue, replaced by a bubble when nothing is buffered.
    always_comb begin
        head            = mem[rd_ptr];
        ifid2id_valid_o = not_empty;
        ifid2if_ready_o = not_full;
        ifid_cnt_o      = count;
        if (not_empty) begin
            ifid2id_addr_o = head.addr;
            ifid2id_ins_o  = head.ins;
        end else begin
            ifid2id_addr_o = RST_ADDR;
            ifid2id_ins_o  = NOP_INS;
        end
    end

endmodule : if_id_buf
